mult_add_operator: RTL and testbench
====================================

Name: mult_add_operator

Overview:
- Sequential shift-add multiply-accumulate unit: result = multiplicand * multiplier + addend.
- Performs the inverse of the divider operator. It rebuilds a dividend from quotient, divisor and remainder, and is used to self-check division results.
- Uses the same start/done operator handshake as the other ALU16 operators and sits beside them in the operator bank.

Parameters:
- N, 8, operand width in bits; result is 2N bits wide.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- multiplicand  input  N  operand A, captured on the accepting edge
- multiplier  input  N  operand B, captured on the accepting edge
- addend  input  N  operand C, captured on the accepting edge
- result  output  2N  A*B+C, registered, held until next completion
- done  output  1  single-cycle completion pulse
- busy  output  1  high while state is not IDLE
- overflow  output  1  result[2N-1:N] nonzero, meaning the result does not fit N bits; updated with result

Behaviour:
- Reset: clk is the clock; rst_n is asynchronous, active-low.
  - While rst_n is low: result=0, done=0, busy=0, overflow=0, state=IDLE, internal acc/count cleared.
  - Reset asserted mid-operation aborts the operation; no done is produced.
- FSM states: IDLE, CALC, FINISH; encoding comes from the package. Illegal state goes to IDLE.
- IDLE:
  - done <= 0.
  - If start is sampled high: acc <= zero-extended addend (2N), mcand <= zero-extended multiplicand (2N), mplier <= multiplier, count <= 0, and the state moves to CALC.
- CALC, one iteration per cycle:
  - If mplier[0] is 1: acc <= acc + mcand.
  - mcand <<= 1; mplier >>= 1; count++.
  - When count == N-1, go to FINISH. This gives exactly N CALC cycles.
- FINISH:
  - result <= acc, overflow <= |acc[2N-1:N], done <= 1.
  - State goes to IDLE.
- Latency: with start sampled at edge 0, done is high after edge N+1 and clears after edge N+2.
- busy is high from edge 0 through edge N+1. It is low in the done cycle.
- Arithmetic:
  - acc is 2N bits wide.
  - The maximum value is (2^N-1)^2 + (2^N-1) = 2^2N - 2^N, so no wrap-around can occur.
  - All arithmetic is unsigned.
- Handshake:
  - start while busy is ignored; it is not queued.
  - start during the done cycle is accepted, so back-to-back operations are allowed.
  - Operand inputs may change freely after the accepting edge.
- Hold rules:
  - result and overflow hold their values between completions.
  - A reset or an aborted operation leaves them at 0.
- Zero operands need no special case: multiplier=0 or multiplicand=0 gives result=addend.

Optional Feature:
- Macro: MULT_ADD_EARLY_EXIT_EN.
- Defined: CALC moves to FINISH after the iteration in which the shifted mplier (mplier>>1) becomes 0, or when count == N-1, whichever comes first.
  - CALC cycle count = index of the highest set bit of multiplier + 1.
  - multiplier=0 still takes 1 CALC cycle.
  - done arrives that many cycles after the accepting edge, plus 1.
- Undefined: fixed N CALC cycles as described above.
- result and overflow values are identical in both builds.

Decomposition:
- Shared ALU package holds:
  - State encoding localparams IDLE/CALC/FINISH (2 bits), shared with the divider operator.
  - Default operand width constant.
  - A clog2 width helper for sizing count.
- No sub-module is natural: the datapath is one adder plus shifters, so the block stays a single module.

Test Plan:
- N=8, multiplicand=25, multiplier=10, addend=3, 1-cycle start -> result=253, overflow=0, done exactly 9 cycles after the start edge (5 cycles with MULT_ADD_EARLY_EXIT_EN), busy low in the done cycle.
- multiplicand=255, multiplier=255, addend=255 -> result=0xFF00 (65280), overflow=1.
- multiplier=0, addend=42 -> result=42, overflow=0; with MULT_ADD_EARLY_EXIT_EN, done 2 cycles after the start edge.
- Second start with different operands pulsed 3 cycles into an operation -> ignored; result=253 from the first operation; exactly one done pulse.
- rst_n pulsed low in the 4th CALC cycle -> result/done/busy/overflow all 0 immediately; no done pulse. A following 12*12+0 -> result=144.
- start held high across the done cycle with quotient=21, divisor=12, remainder=1 -> done for the first operation, then the second is accepted at once; second result=253, which equals the original dividend.

Source files
------------

// File: rtl/mult_add_operator_pkg.sv
// Shared ALU16 operator definitions: state encoding, default operand width
// and a width helper used to size iteration counters.
package mult_add_operator_pkg;

  localparam int unsigned ALU_OPERAND_W = 8;

  // Operator FSM encoding, shared by the multiply-add and divider operators.
  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] alu_state_t;

  localparam alu_state_t IDLE   = 2'd0;
  localparam alu_state_t CALC   = 2'd1;
  localparam alu_state_t FINISH = 2'd2;

  // Bits needed to count 0..v-1; never less than 1.
  function automatic int unsigned clog2_w(input int unsigned v);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << w) < v) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mult_add_operator.sv
// Sequential shift-add multiply-accumulate: result = multiplicand*multiplier+addend.
// Optional MULT_ADD_EARLY_EXIT_EN stops iterating once the remaining multiplier bits are 0.
module mult_add_operator
  import mult_add_operator_pkg::*;
#(
  parameter int unsigned N = ALU_OPERAND_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic [N-1:0]   addend,
  output logic [2*N-1:0] result,
  output logic           done,
  output logic           busy,
  output logic           overflow
);

  localparam int unsigned W2    = 2 * N;
  localparam int unsigned CNT_W = clog2_w(N);

  alu_state_t       state_q,  state_d;
  logic [W2-1:0]    acc_q,    acc_d;
  logic [W2-1:0]    mcand_q,  mcand_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [W2-1:0]    result_d;
  logic             overflow_d;
  logic             done_d;
  logic             busy_d;
  logic             last_iter;

  // Final iteration detect; the early-exit build also stops when no multiplier bits remain.
  always_comb begin
`ifdef MULT_ADD_EARLY_EXIT_EN
    last_iter = (count_q == CNT_W'(N - 1)) || ((mplier_q >> 1) == '0);
`else
    last_iter = (count_q == CNT_W'(N - 1));
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    count_d    = count_q;
    result_d   = result;
    overflow_d = overflow;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = W2'(addend);
          mcand_d  = W2'(multiplicand);
          mplier_d = multiplier;
          count_d  = '0;
          state_d  = CALC;
        end
      end

      CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (last_iter) state_d = FINISH;
      end

      FINISH: begin
        result_d   = acc_q;
        overflow_d = |acc_q[W2-1:N];
        done_d     = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      result   <= result_d;
      overflow <= overflow_d;
      done     <= done_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_mult_add_operator.sv
// Scoreboard bench for mult_add_operator (N=8): results, overflow, latency,
// handshake, abort-by-reset and back-to-back acceptance.
module tb_mult_add_operator;

  localparam int unsigned N = 8;

  typedef struct packed {
    logic [2*N-1:0] res;
    logic           ovf;
    int unsigned    lat;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [N-1:0]   addend;
  logic [2*N-1:0] result;
  logic           done;
  logic           busy;
  logic           overflow;

  int   errors;
  int   checks;
  exp_t sb[$];

  mult_add_operator #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .result       (result),
    .done         (done),
    .busy         (busy),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges from the accepting edge until done is seen.
  function automatic int unsigned exp_lat(input logic [N-1:0] m);
`ifdef MULT_ADD_EARLY_EXIT_EN
    int unsigned h;
    h = 0;
    for (int i = 0; i < int'(N); i++) if (m[i]) h = i;
    return h + 2;
`else
    return N + 1;
`endif
  endfunction

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [N-1:0] c);
    exp_t e;
    int unsigned v;
    v     = int'(a) * int'(b) + int'(c);
    e.res = 16'(v);
    e.ovf = (v >= 256);
    e.lat = exp_lat(b);
    return e;
  endfunction

  // Pulse start for one edge and record the expected outcome.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    start        = 1'b1;
    sb.push_back(model(a, b, c));
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = $urandom_range(0, 255);
    multiplier   = $urandom_range(0, 255);
    addend       = $urandom_range(0, 255);
  endtask

  task automatic wait_done(input int unsigned from, output int unsigned cyc, output bit ok);
    cyc = from;
    ok  = 1'b0;
    while (cyc < 60 && !ok) begin
      @(posedge clk); #1;
      cyc++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0; multiplier = '0; addend = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (result !== 16'd0) begin errors++; $display("FAIL reset_result got=%0d want=0", result); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_one(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] c);
    int unsigned cyc;
    bit ok;
    exp_t e;
    start_op(a, b, c);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_accept got=%b want=1", tag, busy); end
    wait_done(0, cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL %s timeout no done within %0d cycles", tag, cyc); end
    else begin
      if (cyc !== e.lat) begin errors++; $display("FAIL %s latency got=%0d want=%0d", tag, cyc, e.lat); end
      checks++; if (result !== e.res) begin errors++; $display("FAIL %s result got=%0d want=%0d", tag, result, e.res); end
      checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL %s ovf got=%b want=%b", tag, overflow, e.ovf); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_in_done got=%b want=0", tag, busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_not_pulse got=%b want=0", tag, done); end
      checks++; if (result !== e.res) begin errors++; $display("FAIL %s result_hold got=%0d want=%0d", tag, result, e.res); end
    end
  endtask

  task automatic test_basic();
    run_one("basic", 8'd25, 8'd10, 8'd3);
    run_one("max", 8'd255, 8'd255, 8'd255);
    run_one("zero_mult", 8'd77, 8'd0, 8'd42);
    run_one("zero_mcand", 8'd0, 8'd200, 8'd9);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_one("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)));
  endtask

  task automatic test_ignore_start();
    int unsigned cyc;
    int unsigned extra;
    bit ok;
    exp_t e;
    start_op(8'd25, 8'd10, 8'd3);
    repeat (2) @(posedge clk);
    #1;
    multiplicand = 8'd99; multiplier = 8'd99; addend = 8'd99;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL ignore timeout no done"); end
    else begin
      if (cyc !== e.lat) begin errors++; $display("FAIL ignore latency got=%0d want=%0d", cyc, e.lat); end
      checks++; if (result !== 16'd253) begin errors++; $display("FAIL ignore result got=%0d want=253", result); end
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore extra_activity got=%0d want=0", extra); end
  endtask

  task automatic test_abort_reset();
    int unsigned extra;
    exp_t e;
    start_op(8'd200, 8'd200, 8'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    e = sb.pop_back();
    checks++; if (result !== 16'd0) begin errors++; $display("FAIL abort_result got=%0d want=0", result); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b want=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf got=%b want=0", overflow); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL abort_done_pulses got=%0d want=0", extra); end
    checks++; if (result !== 16'd0) begin errors++; $display("FAIL abort_result_hold got=%0d want=0", result); end
    run_one("after_abort", 8'd12, 8'd12, 8'd0);
  endtask

  task automatic test_back_to_back();
    int unsigned cyc;
    bit ok;
    exp_t e;
    multiplicand = 8'd7; multiplier = 8'd9; addend = 8'd5;
    start = 1'b1;
    sb.push_back(model(8'd7, 8'd9, 8'd5));
    @(posedge clk); #1;
    multiplicand = 8'd21; multiplier = 8'd12; addend = 8'd1;
    sb.push_back(model(8'd21, 8'd12, 8'd1));
    wait_done(0, cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b first timeout"); end
    else begin
      if (cyc !== e.lat) begin errors++; $display("FAIL b2b first_latency got=%0d want=%0d", cyc, e.lat); end
      checks++; if (result !== e.res) begin errors++; $display("FAIL b2b first_result got=%0d want=%0d", result, e.res); end
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b second_accept busy got=%b want=1", busy); end
    wait_done(0, cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b second timeout"); end
    else begin
      if (cyc !== e.lat) begin errors++; $display("FAIL b2b second_latency got=%0d want=%0d", cyc, e.lat); end
      checks++; if (result !== 16'd253) begin errors++; $display("FAIL b2b dividend got=%0d want=253", result); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b ovf got=%b want=0", overflow); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_random();
    test_ignore_start();
    test_abort_reset();
    test_back_to_back();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
